// File: rtl/gs_arb_pkg.sv
// Shared types, constants and the memory-size range check for the GS memory arbiter.
package gs_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   localparam logic [1:0] GS_SIZE_512K = 2'd0;
   localparam logic [1:0] GS_SIZE_1M   = 2'd1;

   // Only address bits [20:19] decide the range; codes 2/3 (2MB) accept everything.
   function automatic logic gs_in_range(input logic [1:0] addr_hi, input logic [1:0] size);
      logic ok;
      case (size)
         GS_SIZE_512K: ok = (addr_hi == 2'b00);
         GS_SIZE_1M:   ok = ~addr_hi[1];
         default:      ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Captures a one-cycle request strobe and holds it, with a pending flag, until the arbiter retires it.
module arb_req_latch
   import gs_arb_pkg::*;
#(
   parameter int AW = 21
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          rd,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    din,
   input  logic          clr,
   output logic          pend,
   output logic [AW-1:0] req_addr,
   output logic [7:0]    req_din,
   output logic          req_wr
);

   // A new strobe takes priority over a retirement in the same cycle.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         pend     <= 1'b0;
         req_addr <= {AW{1'b0}};
         req_din  <= 8'h00;
         req_wr   <= 1'b0;
      end else if (rd || wr) begin
         pend     <= 1'b1;
         req_addr <= addr;
         req_din  <= din;
         req_wr   <= wr;
      end else if (clr) begin
         pend     <= 1'b0;
      end
   end

endmodule

// File: rtl/gs_mem_arb.sv
// Round-robin arbiter sharing the byte-wide DDRAM bridge between the GS core (A) and the loader (B).
module gs_mem_arb
   import gs_arb_pkg::*;
#(
   parameter int AW      = 21,
   parameter int TIMEOUT = 4095
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic [1:0]    gs_size,
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_din,
   input  logic          a_rd,
   input  logic          a_wr,
   output logic [7:0]    a_dout,
   output logic          a_wait,
   input  logic [AW-1:0] b_addr,
   input  logic [7:0]    b_din,
   input  logic          b_wr,
   output logic          b_busy,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_rd,
   output logic          mem_we,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ready,
   output logic          timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic          pend_a, pend_b, req_wr_a, req_wr_b;
   logic [AW-1:0] req_addr_a, req_addr_b;
   logic [7:0]    req_din_a, req_din_b;
   logic          clr_a, clr_b;

   logic [1:0]    state;
   port_t         grant, last_grant;
   logic          grant_wr, skip;
   logic [CW-1:0] wd_cnt;

   logic          pick_a, grant_ok, sel_wr, sel_in_range;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_din;
   logic          mem_done, wd_expire, finish, active;

   arb_req_latch #(.AW(AW)) u_latch_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .rd(a_rd), .wr(a_wr), .addr(a_addr), .din(a_din),
      .clr(clr_a), .pend(pend_a), .req_addr(req_addr_a), .req_din(req_din_a), .req_wr(req_wr_a)
   );

   arb_req_latch #(.AW(AW)) u_latch_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .rd(1'b0), .wr(b_wr), .addr(b_addr), .din(b_din),
      .clr(clr_b), .pend(pend_b), .req_addr(req_addr_b), .req_din(req_din_b), .req_wr(req_wr_b)
   );

   // Grant selection, completion detection and the requester-facing busy flags.
   always_comb begin
      pick_a       = pend_a & (~pend_b | (last_grant == PORT_B));
      sel_addr     = pick_a ? req_addr_a : req_addr_b;
      sel_din      = pick_a ? req_din_a : req_din_b;
      sel_wr       = pick_a ? req_wr_a : req_wr_b;
      sel_in_range = gs_in_range(sel_addr[20:19], gs_size);
      grant_ok     = (state == ST_IDLE) & (pend_a | pend_b) & mem_ready;
      // The first WAIT cycle (counter zero) still sees the bridge's stale ready level.
      mem_done     = (state == ST_WAIT) & (wd_cnt != {CW{1'b0}}) & mem_ready;
      wd_expire    = (state == ST_WAIT) & ~mem_done & (wd_cnt == CW'(TIMEOUT));
      finish       = mem_done | wd_expire | ((state == ST_DONE) & skip);
      active       = (state == ST_ISSUE) | (state == ST_WAIT) | ((state == ST_DONE) & skip);
      clr_a        = finish & (grant == PORT_A);
      clr_b        = finish & (grant == PORT_B);
      a_wait       = a_rd | a_wr | pend_a | (active & (grant == PORT_A));
      b_busy       = b_wr | pend_b | (active & (grant == PORT_B));
   end

   // Arbitration FSM, watchdog and registered bridge/result outputs.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         grant       <= PORT_A;
         last_grant  <= PORT_B;
         grant_wr    <= 1'b0;
         skip        <= 1'b0;
         wd_cnt      <= {CW{1'b0}};
         mem_addr    <= {AW{1'b0}};
         mem_din     <= 8'h00;
         mem_rd      <= 1'b0;
         mem_we      <= 1'b0;
         a_dout      <= 8'hFF;
         timeout_err <= 1'b0;
      end else begin
         if (finish) begin
            last_grant <= grant;
            if ((grant == PORT_A) && !grant_wr) begin
               a_dout <= mem_done ? mem_dout : 8'hFF;
            end
         end
         if (wd_expire) begin
            timeout_err <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (grant_ok) begin
                  grant    <= pick_a ? PORT_A : PORT_B;
                  grant_wr <= sel_wr;
                  skip     <= ~sel_in_range;
                  if (sel_in_range) begin
                     mem_addr <= sel_addr;
                     mem_din  <= sel_din;
                     mem_rd   <= ~sel_wr;
                     mem_we   <= sel_wr;
                     state    <= ST_ISSUE;
                  end else begin
                     state    <= ST_DONE;
                  end
               end
            end
            ST_ISSUE: begin
               mem_rd <= 1'b0;
               mem_we <= 1'b0;
               wd_cnt <= {CW{1'b0}};
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_done || wd_expire) begin
                  state <= ST_DONE;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               skip  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/gs_mem_arb.md
# gs_mem_arb

Two-port arbiter that shares the single byte-wide DDRAM bridge used as General Sound (GS) memory between the GS core memory port (port A) and the HPS loader preload path (port B). It latches strobed requests from both ports so none are lost while the bridge is busy, and grants them round-robin. It applies the GS memory-size mask: out-of-range reads return 8'hFF and out-of-range writes are dropped, with no DDRAM access in either case. A watchdog aborts any transaction the bridge never completes. It sits between the GS/loader logic and the `ddram` instance in the top level, all on `clk_sys`.

## Interface
Parameters:
- `AW`, 21: byte address width of both ports and the bridge.
- `TIMEOUT`, 4095: maximum cycles to wait for `mem_ready` before aborting.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `gs_size`  in  2  memory size: 0 = 512KB, 1 = 1MB, 2/3 = 2MB. Sampled when a request is granted.
- `a_addr`  in  AW  port A address.
- `a_din`  in  8  port A write data.
- `a_rd`  in  1  port A read strobe, one cycle.
- `a_wr`  in  1  port A write strobe, one cycle.
- `a_dout`  out  8  port A read data. Held until the next port-A read completes.
- `a_wait`  out  1  high from the strobe cycle until the port-A request completes.
- `b_addr`, `b_din`, `b_wr`  in  AW/8/1  port B write-only request; `b_wr` is a one-cycle strobe.
- `b_busy`  out  1  high while a port-B request is pending or in flight.
- `mem_addr`  out  AW  bridge address.
- `mem_din`  out  8  bridge write data.
- `mem_rd`, `mem_we`  out  1  bridge command pulses, one cycle.
- `mem_dout`  in  8  bridge read data, valid when `mem_ready` rises.
- `mem_ready`  in  1  bridge idle/done level.
- `timeout_err`  out  1  sticky flag, set on any watchdog abort. Cleared only by reset.

## Operation
- **Per-port latch.** A strobe captures address, data and direction, and sets `pend`.
  - A strobe while `pend` is already set overwrites the captured request. This is a protocol violation by the requester and the bench flags it.
  - `rd` and `wr` high together on port A: the request is treated as a write.
- **Range check at grant.** A request is out of range when:
  - `gs_size`=0 and `addr[20:19]` is nonzero, or
  - `gs_size`=1 and `addr[20]` is set.
- **FSM states: IDLE, ISSUE, WAIT, DONE.**
  - **IDLE.** If any `pend` is set and `mem_ready` is high, grant one port.
    - Both pending: grant the port not granted last (`last_grant` register; reset value B, so A wins the first tie).
    - Out-of-range grant: skip the bridge and go to DONE. A read returns 8'hFF; a write is discarded.
    - In-range grant: go to ISSUE.
  - **ISSUE.** Drive `mem_addr`/`mem_din` and pulse `mem_rd` or `mem_we` for exactly one cycle. Clear the watchdog counter. Go to WAIT.
  - **WAIT.** Ignore `mem_ready` in the first WAIT cycle, because the bridge deasserts it one cycle after the command.
    - Afterwards, `mem_ready` high: capture `mem_dout` for a read and go to DONE.
    - Counter reaches TIMEOUT: set `timeout_err`, return 8'hFF for a read, go to DONE.
  - **DONE.** Clear the granted port's `pend`, update `a_dout` for a port-A read, update `last_grant`, return to IDLE.
- **Same-cycle clear and new strobe.** A new strobe on a port in the same cycle its `pend` is cleared in DONE is latched; the strobe wins.
- `mem_addr`/`mem_din` hold their last values outside ISSUE.

## Timing
- **Reset values:** `a_dout`=8'hFF, `a_wait`=0, `b_busy`=0, `mem_rd`=`mem_we`=0, `mem_addr`=0, `mem_din`=0, `timeout_err`=0, state IDLE, both `pend`=0, `last_grant`=B.
- `a_wait` is combinational from `a_rd|a_wr|pend_A|granted_A`, so it is high in the strobe cycle itself. `b_busy` is built the same way.
- **Latency, strobe at cycle 0, idle arbiter:**
  - In range: `mem_rd`/`mem_we` at cycle 2. The bridge returns `mem_ready` at cycle r ≥ 4; `a_dout` updates and `a_wait` falls at r+1.
  - Out of range: completes with `a_wait` low at cycle 3.
- **Throughput.** Back-to-back grants are separated by at least one IDLE cycle.
- **Reset mid-transaction.** Abandon the transaction immediately and clear `pend`. The bridge finishes its own cycle; the arbiter waits for `mem_ready` high in IDLE before issuing again.

## Structure
- Package `gs_arb_pkg`: state enum (IDLE/ISSUE/WAIT/DONE), port-id enum (PORT_A/PORT_B), size codes, and the range-check function `gs_in_range(addr, size)`.
- Sub-module `arb_req_latch`: strobe capture plus `pend` flag. Instantiated twice; port B has its read input tied low.
- Top: grant logic, FSM, watchdog counter, output registers.

## Test plan
- **Single read.** A reads 0x00123, `gs_size`=2, bridge model returns 0x5A after 3 cycles → one `mem_rd` pulse with `mem_addr`=0x00123; `a_dout`=0x5A; `a_wait` falls at cycle 6.
- **Tie.** A write and B write strobed in the same cycle → A is issued first, B second; exactly two `mem_we` pulses; `b_busy` falls after the second completes.
- **Out-of-range access.** `gs_size`=0: read 0x80000 → `a_dout`=0xFF with no `mem_rd`. Write 0x80000 → no `mem_we`.
- **Strobe while busy.** B strobes during A's WAIT → B is issued immediately after A's DONE; no request is lost.
- **Watchdog.** Bridge model holds `mem_ready` low → after TIMEOUT cycles `timeout_err`=1, `a_dout`=0xFF, `a_wait` falls. A later normal read still succeeds.
- **Reset during WAIT.** `reset_n` low for one cycle during WAIT → all outputs return to reset values; the next request is issued only after `mem_ready` is high.
